sobel_edge_writer: RTL

- Consumer end of the Sobel pixel stream: takes the 1-bit `result` per streamed input pixel, undoes the line-buffer latency, and packs edge bits into an internal 1-bit-per-pixel edge frame memory.
- Flushes the bottom rows that never receive a valid result, then signals frame completion.
- Provides a registered random-access read port so the VGA side can display the edge map.

---
 rtl/sobel_edge_writer.sv | 117 +++++++++++
 1 files changed

// File: rtl/sobel_edge_writer.sv
// Sobel result sink: re-aligns the 1-bit edge decision by the line latency, packs 16 pixels per
// word into the edge frame memory, zero-fills the bottom rows at frame end and serves VGA reads.
module sobel_edge_writer #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned Y_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       result,
  input  logic       rd_en,
  input  logic [9:0] rd_x,
  input  logic [9:0] rd_y,
  output logic       rd_edge,
  output logic       rd_valid,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned WordsPerLine = H_ACT / 16;
  localparam int unsigned Depth        = WordsPerLine * V_ACT;
  localparam int unsigned AddrW        = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned FlushWords   = Y_LAT * WordsPerLine;
  localparam int unsigned FlushBase    = (V_ACT - Y_LAT) * WordsPerLine;

  typedef enum logic [0:0] {StStream, StFlush} state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [15:0]        pack_q, pack_d;
  logic               done_q, done_d;
  logic               rd_edge_q, rd_edge_d;
  logic               rd_valid_q, rd_valid_d;

  logic [15:0]        mem [Depth];

  logic               in_ok, frame_last, flush_last, rd_in_range;
  logic [15:0]        pack_merge;
  logic [AddrW-1:0]   wr_addr, rd_addr;
  logic               mem_we;
  logic [AddrW-1:0]   mem_waddr;
  logic [15:0]        mem_wdata;

  // Rows above Y_LAT carry results for pixels that do not exist, so they are dropped.
  assign in_ok = in_valid && (state_q == StStream) && (32'(y_pixel) >= Y_LAT) &&
                 (32'(x_pixel) < H_ACT) && (32'(y_pixel) < V_ACT);
  assign frame_last  = (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));
  assign flush_last  = (flush_cnt_q == AddrW'(FlushWords - 1));
  assign wr_addr     = AddrW'(32'(y_pixel - 10'(Y_LAT)) * WordsPerLine + 32'(x_pixel[9:4]));
  assign rd_addr     = AddrW'(32'(rd_y) * WordsPerLine + 32'(rd_x[9:4]));
  assign rd_in_range = (32'(rd_x) < H_ACT) && (32'(rd_y) < V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StStream;
      flush_cnt_q <= '0;
      pack_q      <= '0;
      done_q      <= 1'b0;
      rd_edge_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pack_q      <= pack_d;
      done_q      <= done_d;
      rd_edge_q   <= rd_edge_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStream: if (in_ok && frame_last) state_d = StFlush;
      StFlush:  if (flush_last) state_d = StStream;
      default:  state_d = StStream;
    endcase
  end

  always_comb begin
    pack_merge = (x_pixel[3:0] == 4'd0) ? 16'd0 : pack_q;
    pack_merge[x_pixel[3:0]] = result;
    pack_d      = in_ok ? pack_merge : pack_q;
    flush_cnt_d = (state_q == StFlush) ? flush_cnt_q + AddrW'(1) : '0;
    done_d      = (state_q == StFlush) && flush_last;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = pack_merge;
    if (in_ok && (x_pixel[3:0] == 4'd15)) begin
      mem_we = 1'b1;
    end else if (state_q == StFlush) begin
      mem_we    = 1'b1;
      mem_waddr = AddrW'(FlushBase) + flush_cnt_q;
      mem_wdata = 16'd0;
    end
    if (reset) mem_we = 1'b0;
    rd_valid_d = rd_en;
    rd_edge_d  = rd_edge_q;
    if (rd_en) rd_edge_d = rd_in_range ? mem[rd_addr][rd_x[3:0]] : 1'b0;
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    busy       = (state_q == StFlush);
    frame_done = done_q;
    rd_edge    = rd_edge_q;
    rd_valid   = rd_valid_q;
  end

endmodule
